// File: rtl/de0_display_pkg.sv
// Shared types and constants for the DE0 seven-segment display path.
// Segment patterns are active-low, bit0=a .. bit6=g.
package de0_display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      SWITCH = 2'd2
   } state_t;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational table lookup.
module hex_seg_decode
   import de0_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of HEX0..HEX3 with minimum dwell and preemption.
// Define HEX_OWNER_DP_EN to light the DP of digit (owner mod 4) while granted.
module hex_display_arbiter
   import de0_display_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 50000000
)(
   input  logic                   CLOCK_50,
   input  logic                   RESET,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*16-1:0]  req_data,
   input  logic [NUM_REQ*4-1:0]   req_dp,
   output logic [NUM_REQ-1:0]     grant,
   output logic [6:0]             HEX0_D,
   output logic [6:0]             HEX1_D,
   output logic [6:0]             HEX2_D,
   output logic [6:0]             HEX3_D,
   output logic                   HEX0_DP,
   output logic                   HEX1_DP,
   output logic                   HEX2_DP,
   output logic                   HEX3_DP
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [DW-1:0] HOLD_MAX = DW'(HOLD_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   state_t                 state;
   logic [IW-1:0]          owner;
   logic [IW-1:0]          rr_ptr;
   logic [IW-1:0]          pick;
   logic [DW-1:0]          dwell;
   logic [NUM_REQ-1:0]     grant_q;
   logic                   any_req;
   logic                   owner_req;
   logic                   preempt;
   logic [15:0]            owner_data;
   logic [3:0]             owner_dp;
   logic [NUM_DIGITS-1:0]  dp_next;
   logic [NUM_DIGITS-1:0]  dp_q;
   logic [6:0]             seg_dec [NUM_DIGITS];
   logic [6:0]             seg_q [NUM_DIGITS];

   // First active request scanning from p upward, wrapping at NUM_REQ.
   function automatic logic [IW-1:0] rr_pick(
      input logic [NUM_REQ-1:0] r,
      input logic [IW-1:0]      p
   );
      logic [IW-1:0] sel;
      logic          hit;
      int            j;
      sel = p;
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(p) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!hit && r[j]) begin
            hit = 1'b1;
            sel = IW'(j);
         end
      end
      return sel;
   endfunction

   assign any_req    = |req;
   assign owner_req  = req[owner];
   assign preempt    = (dwell == HOLD_MAX) && |(req & ~grant_q);
   assign pick       = rr_pick(req, rr_ptr);
   assign owner_data = req_data[int'(owner)*16 +: 16];
   assign owner_dp   = req_dp[int'(owner)*4 +: 4];

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state   <= IDLE;
         grant_q <= '0;
         owner   <= '0;
         rr_ptr  <= '0;
         dwell   <= '0;
      end else begin
         unique case (state)
            IDLE, SWITCH: begin
               if (any_req) begin
                  state   <= GRANT;
                  owner   <= pick;
                  grant_q <= ONE << pick;
                  dwell   <= '0;
               end else begin
                  state   <= IDLE;
               end
            end
            GRANT: begin
               if (!owner_req || preempt) begin
                  state   <= SWITCH;
                  grant_q <= '0;
                  dwell   <= '0;
                  rr_ptr  <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
               end else if (dwell != HOLD_MAX) begin
                  dwell   <= dwell + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

`ifdef HEX_OWNER_DP_EN
   logic [1:0] owner_digit;

   assign owner_digit = 2'(int'(owner) % NUM_DIGITS);

   always_comb begin
      dp_next = ~owner_dp;
      dp_next[owner_digit] = 1'b0;
   end
`else
   assign dp_next = ~owner_dp;
`endif

   for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_dec
      hex_seg_decode u_dec (
         .nibble (owner_data[4*n +: 4]),
         .seg    (seg_dec[n])
      );
   end

   // SWITCH leaves the last owner's pattern on the digits.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         for (int n = 0; n < NUM_DIGITS; n++) seg_q[n] <= SEG_BLANK;
         dp_q <= '1;
      end else begin
         unique case (state)
            IDLE: begin
               for (int n = 0; n < NUM_DIGITS; n++) seg_q[n] <= SEG_BLANK;
               dp_q <= '1;
            end
            GRANT: begin
               for (int n = 0; n < NUM_DIGITS; n++) seg_q[n] <= seg_dec[n];
               dp_q <= dp_next;
            end
            default: begin
               dp_q <= dp_q;
            end
         endcase
      end
   end

   assign grant   = grant_q;
   assign HEX0_D  = seg_q[0];
   assign HEX1_D  = seg_q[1];
   assign HEX2_D  = seg_q[2];
   assign HEX3_D  = seg_q[3];
   assign HEX0_DP = dp_q[0];
   assign HEX1_DP = dp_q[1];
   assign HEX2_DP = dp_q[2];
   assign HEX3_DP = dp_q[3];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter, NUM_REQ=4, HOLD_CYCLES=8.
// Honours HEX_OWNER_DP_EN when computing expected decimal points.
module tb_hex_display_arbiter;

   localparam logic [15:0] D0 = 16'h1234;
   localparam logic [15:0] D1 = 16'hABCD;
   localparam logic [15:0] D2 = 16'h5678;
   localparam logic [15:0] D3 = 16'h9EF0;
   localparam logic [15:0] DF = 16'hFFFF;
   localparam logic [15:0] DPS = 16'h0005;

   localparam logic [27:0] S_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [27:0] S_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] S_ABCD  = {7'h08, 7'h03, 7'h46, 7'h21};
   localparam logic [27:0] S_5678  = {7'h12, 7'h02, 7'h78, 7'h00};
   localparam logic [27:0] S_FFFF  = {7'h0E, 7'h0E, 7'h0E, 7'h0E};

   localparam logic [3:0] DP_O0 = 4'b1010;
`ifdef HEX_OWNER_DP_EN
   localparam logic [3:0] DP_O1 = 4'b1101;
   localparam logic [3:0] DP_O2 = 4'b1011;
`else
   localparam logic [3:0] DP_O1 = 4'b1111;
   localparam logic [3:0] DP_O2 = 4'b1111;
`endif

   typedef struct {
      logic        rst;
      logic [3:0]  rq;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [3:0]  g;
      logic [27:0] hex;
      logic [3:0]  dp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic [15:0] req_dp;
   logic [3:0]  grant;
   logic [6:0]  hex0, hex1, hex2, hex3;
   logic        dp0, dp1, dp2, dp3;

   int checks = 0;
   int errors = 0;
   vec_t vecs [13];
   logic [3:0] exp_g;

   always #5 clk = ~clk;

   hex_display_arbiter #(
      .NUM_REQ     (4),
      .HOLD_CYCLES (8)
   ) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .req      (req),
      .req_data (req_data),
      .req_dp   (req_dp),
      .grant    (grant),
      .HEX0_D   (hex0),
      .HEX1_D   (hex1),
      .HEX2_D   (hex2),
      .HEX3_D   (hex3),
      .HEX0_DP  (dp0),
      .HEX1_DP  (dp1),
      .HEX2_DP  (dp2),
      .HEX3_DP  (dp3)
   );

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] hex_now();
      return {hex3, hex2, hex1, hex0};
   endfunction

   function automatic logic [3:0] dp_now();
      return {dp3, dp2, dp1, dp0};
   endfunction

   initial begin
      rst = 1'b1;
      req = '0;
      req_data = {D3, D2, D1, D0};
      req_dp = DPS;

      // reset then 20 idle cycles
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle_grant_%0d", i), 32'(grant), 32'h0);
         check($sformatf("idle_hex_%0d", i), 32'(hex_now()), 32'(S_BLANK));
         check($sformatf("idle_dp_%0d", i), 32'(dp_now()), 32'hF);
      end

      // table: grant latency, display lag, live update, switch, rotation pointer
      vecs[0]  = '{1'b1, 4'h0, D0,   D1, 4'h0, S_BLANK, 4'hF};
      vecs[1]  = '{1'b0, 4'h0, D0,   D1, 4'h0, S_BLANK, 4'hF};
      vecs[2]  = '{1'b0, 4'h1, D0,   D1, 4'h1, S_BLANK, 4'hF};
      vecs[3]  = '{1'b0, 4'h1, D0,   D1, 4'h1, S_1234,  DP_O0};
      vecs[4]  = '{1'b0, 4'h1, D1,   D1, 4'h1, S_ABCD,  DP_O0};
      vecs[5]  = '{1'b0, 4'h0, D0,   D1, 4'h0, S_1234,  DP_O0};
      vecs[6]  = '{1'b0, 4'h0, D0,   D1, 4'h0, S_1234,  DP_O0};
      vecs[7]  = '{1'b0, 4'h0, D0,   D1, 4'h0, S_BLANK, 4'hF};
      vecs[8]  = '{1'b0, 4'h3, D0,   D1, 4'h2, S_BLANK, 4'hF};
      vecs[9]  = '{1'b0, 4'h3, D0,   D1, 4'h2, S_ABCD,  DP_O1};
      vecs[10] = '{1'b0, 4'h1, D0,   D1, 4'h0, S_ABCD,  DP_O1};
      vecs[11] = '{1'b0, 4'h1, D0,   D1, 4'h1, S_ABCD,  DP_O1};
      vecs[12] = '{1'b0, 4'h1, D0,   D1, 4'h1, S_1234,  DP_O0};

      for (int i = 0; i < 13; i++) begin
         rst = vecs[i].rst;
         req = vecs[i].rq;
         req_data = {D3, D2, vecs[i].d1, vecs[i].d0};
         tick();
         check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
         check($sformatf("vec%0d_hex", i), 32'(hex_now()), 32'(vecs[i].hex));
         check($sformatf("vec%0d_dp", i), 32'(dp_now()), 32'(vecs[i].dp));
      end

      // steady req=0011 from reset: strict rotation with dwell of 9 grants
      req_data = {D3, D2, D1, D0};
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      req = 4'b0011;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k <= 9) exp_g = 4'b0001;
         else if (k == 10) exp_g = 4'b0000;
         else if (k <= 19) exp_g = 4'b0010;
         else if (k == 20) exp_g = 4'b0000;
         else exp_g = 4'b0001;
         check($sformatf("rot_grant_%0d", k), 32'(grant), 32'(exp_g));
         if (k == 12)
            check("rot_hex_owner1", 32'(hex_now()), 32'(S_ABCD));
      end

      // owner 0 drops at dwell 3 with req[2] waiting, then preemption of 2
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      req = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("drop_own0_%0d", k), 32'(grant), 32'h1);
      end
      req = 4'b0100;
      tick();
      check("drop_switch", 32'(grant), 32'h0);
      tick();
      check("drop_grant2", 32'(grant), 32'h4);
      req = 4'b0101;
      tick();
      check("drop_hex2", 32'(hex_now()), 32'(S_5678));
      check("drop_dp2", 32'(dp_now()), 32'(DP_O2));
      for (int k = 8; k <= 14; k++) begin
         tick();
         check($sformatf("drop_hold2_%0d", k), 32'(grant), 32'h4);
      end
      tick();
      check("preempt_switch", 32'(grant), 32'h0);
      tick();
      check("preempt_grant0", 32'(grant), 32'h1);

      // reset mid-grant with all-F data, then rr_ptr must be back at 0
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      req_data = {D3, D2, DF, D0};
      req = 4'b0010;
      tick();
      check("rst_g1", 32'(grant), 32'h2);
      tick();
      check("rst_hexF", 32'(hex_now()), 32'(S_FFFF));
      req = 4'b0000;
      tick();
      check("rst_sw", 32'(grant), 32'h0);
      req = 4'b0010;
      tick();
      check("rst_g1b", 32'(grant), 32'h2);
      tick();
      check("rst_hexFb", 32'(hex_now()), 32'(S_FFFF));
      rst = 1'b1;
      req = 4'b0011;
      tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_hex", 32'(hex_now()), 32'(S_BLANK));
      check("rst_dp", 32'(dp_now()), 32'hF);
      rst = 1'b0;
      req = 4'b0110;
      tick();
      check("rst_rrptr", 32'(grant), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
